seq_scan_ctrl: RTL and testbench

//   Scan controller for the single-shot serial sequence detector (x/y, stops after one match).

---
 rtl/seq_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// Scan controller: loads a word by valid/ready handshake, shifts it MSB-first into a
// serial sequence detector, and reports whether and where the first match occurred.
module seq_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned POS_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_abort,
    output logic             o_det_rst,
    output logic             o_det_x,
    input  logic             i_det_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_found,
    output logic             o_aborted,
    output logic [POS_W-1:0] o_match_pos
);

    localparam logic [POS_W-1:0] LP_LAST = POS_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_REPORT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [POS_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_det_rst;
    logic             r_det_x;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic             r_aborted;
    logic [POS_W-1:0] r_match_pos;

    logic [WIDTH-1:0] w_sreg_next;
    logic [POS_W-1:0] w_cnt_inc;
    logic [POS_W-1:0] w_cnt_dec;

    assign w_sreg_next = {r_sreg[WIDTH-2:0], 1'b0};
    assign w_cnt_inc   = r_cnt + POS_W'(1);
    assign w_cnt_dec   = r_cnt - POS_W'(1);

    // Outputs are computed alongside the next state so every one of them is a flop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_det_rst   <= 1'b1;
            r_det_x     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_aborted   <= 1'b0;
            r_match_pos <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_state     <= S_SHIFT;
                        r_sreg      <= i_in_data;
                        r_cnt       <= '0;
                        r_found     <= 1'b0;
                        r_aborted   <= 1'b0;
                        r_match_pos <= '0;
                        r_in_ready  <= 1'b0;
                        r_det_rst   <= 1'b0;
                        r_det_x     <= i_in_data[WIDTH-1];
                        r_busy      <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    r_sreg <= w_sreg_next;
                    r_cnt  <= w_cnt_inc;
                    // A match seen now belongs to the bit consumed one edge earlier.
                    if (i_det_y) begin
                        r_found     <= 1'b1;
                        r_match_pos <= w_cnt_dec;
                        r_state     <= S_REPORT;
                        r_det_rst   <= 1'b1;
                        r_det_x     <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_found   <= 1'b0;
                        r_state   <= S_REPORT;
                        r_det_rst <= 1'b1;
                        r_det_x   <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= S_DRAIN;
                        r_det_x <= 1'b0;
                    end else begin
                        r_det_x <= w_sreg_next[WIDTH-1];
                    end
                end

                S_DRAIN: begin
                    if (i_det_y) begin
                        r_found     <= 1'b1;
                        r_match_pos <= LP_LAST;
                    end else if (i_abort) begin
                        r_aborted <= 1'b1;
                    end else begin
                        r_found     <= 1'b0;
                        r_match_pos <= '0;
                    end
                    r_state   <= S_REPORT;
                    r_det_rst <= 1'b1;
                    r_det_x   <= 1'b0;
                    r_done    <= 1'b1;
                end

                S_REPORT: begin
                    r_state    <= S_IDLE;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_det_rst  <= 1'b1;
                    r_det_x    <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_det_rst   = r_det_rst;
    assign o_det_x     = r_det_x;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_found     = r_found;
    assign o_aborted   = r_aborted;
    assign o_match_pos = r_match_pos;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a 1001 Moore detector model, directed scenarios and random
// words checked against a result model derived from the scan rules.
module tb_seq_scan_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          abort = 1'b0;
    logic          det_rst;
    logic          det_x;
    logic          det_y = 1'b0;
    logic          busy;
    logic          done;
    logic          found;
    logic          aborted;
    logic [PW-1:0] match_pos;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_count = 0;
    int hs_cyc   = 0;
    logic [3:0] det_hist = '0;

    seq_scan_ctrl #(.WIDTH(W), .POS_W(PW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_abort     (abort),
        .o_det_rst   (det_rst),
        .o_det_x     (det_x),
        .i_det_y     (det_y),
        .o_busy      (busy),
        .o_done      (done),
        .o_found     (found),
        .o_aborted   (aborted),
        .o_match_pos (match_pos)
    );

    always #5 clk = ~clk;

    // Detector: recognises 1001, Moore output, sticky until det_rst.
    always @(posedge clk) begin
        if (det_rst) begin
            det_hist <= '0;
            det_y    <= 1'b0;
        end else begin
            det_hist <= {det_hist[2:0], det_x};
            if ({det_hist[2:0], det_x} == 4'b1001) det_y <= 1'b1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready && !reset) begin
            hs_count <= hs_count + 1;
            hs_cyc   <= cyc + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of one scan from the word's send order and the edge (1-based) abort is applied.
    function automatic void ref_scan(input logic [W-1:0] w, input int ab, output int d_edge,
                                     output logic f, output logic a, output int pos);
        int p;
        p = -1;
        for (int k = 3; k < W; k++)
            if (p < 0 && w[W+2-k] && !w[W+1-k] && !w[W-k] && w[W-1-k]) p = k;
        if (p >= 0 && (ab == 0 || p + 2 <= ab)) begin
            d_edge = p + 2; f = 1'b1; a = 1'b0; pos = p;
        end else if (ab != 0 && ab <= W + 1) begin
            d_edge = ab; f = 1'b0; a = 1'b1; pos = 0;
        end else begin
            d_edge = W + 1; f = 1'b0; a = 1'b0; pos = 0;
        end
    endfunction

    // Starts and ends at a negedge; ab = edge index after the handshake carrying abort (0 = none).
    task automatic run_scan(input string tag, input logic [W-1:0] w, input int ab);
        int d_exp, pos_exp, d_got, waitc;
        logic f_exp, a_exp;
        logic [W-1:0] sh;
        ref_scan(w, ab, d_exp, f_exp, a_exp, pos_exp);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, ".ready"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".busy"}, 32'(busy), 1);
        check({tag, ".found_clr"}, 32'(found), 0);
        sh = w;
        d_got = 0;
        for (int k = 1; k <= W + 4 && d_got == 0; k++) begin
            abort = (k == ab);
            if (!det_rst) check({tag, ".det_x"}, 32'(det_x), k <= W ? 32'(sh[W-1]) : 0);
            sh = sh << 1;
            @(posedge clk);
            @(negedge clk);
            if (done) d_got = k;
        end
        abort = 1'b0;
        check({tag, ".done_edge"}, d_got, d_exp);
        check({tag, ".found"}, 32'(found), 32'(f_exp));
        check({tag, ".aborted"}, 32'(aborted), 32'(a_exp));
        check({tag, ".pos"}, 32'(match_pos), pos_exp);
        check({tag, ".rep_ready"}, 32'(in_ready), 0);
        check({tag, ".rep_detrst"}, 32'(det_rst), 1);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 0);
        check({tag, ".idle_ready"}, 32'(in_ready), 1);
        check({tag, ".idle_busy"}, 32'(busy), 0);
        check({tag, ".hold"}, {30'b0, found, aborted}, {30'b0, f_exp, a_exp});
        check({tag, ".hold_pos"}, 32'(match_pos), pos_exp);
    endtask

    initial begin
        int hs0, a_cyc, d_got, dones;
        logic [W-1:0] rw;
        int rab, sp;

        repeat (2) @(negedge clk);
        check("rst.ready", 32'(in_ready), 1);
        check("rst.detrst", 32'(det_rst), 1);
        check("rst.outs", {26'b0, det_x, busy, done, found, aborted, 1'b0}, 0);
        check("rst.pos", 32'(match_pos), 0);
        reset = 1'b0;
        @(negedge clk);

        run_scan("t1", 8'b1001_0000, 0);
        run_scan("t2", 8'b0000_1001, 0);
        run_scan("t3", 8'h00, 0);
        run_scan("t4", 8'b1001_1001, 0);
        run_scan("t4b", 8'b0100_1000, 0);
        run_scan("t5", 8'h00, 3);
        run_scan("t5b", 8'b1001_0000, 5);
        run_scan("t5c", 8'h00, W + 1);

        // Reset pulse across E4 of a scan that would otherwise match.
        in_valid = 1'b1;
        in_data  = 8'b1001_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        #1;
        check("t6.detrst", 32'(det_rst), 1);
        check("t6.busy", 32'(busy), 0);
        check("t6.ready", 32'(in_ready), 1);
        check("t6.res", {29'b0, done, found, aborted}, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6.no_done", dones, 0);
        check("t6.pos", 32'(match_pos), 0);

        // in_valid held while busy: second word accepted only once IDLE is back.
        hs0 = hs_count;
        in_valid = 1'b1;
        in_data  = 8'b1001_0000;
        @(negedge clk);
        a_cyc = hs_cyc;
        in_data = 8'b0000_1001;
        sp = 0;
        while (hs_count != hs0 + 2 && sp < 30) begin
            @(negedge clk);
            sp++;
        end
        in_valid = 1'b0;
        check("t6b.hs_count", hs_count - hs0, 2);
        check("t6b.hs_gap", hs_cyc - a_cyc, 7);
        d_got = 0;
        for (int k = 1; k <= W + 4 && d_got == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) d_got = k;
        end
        check("t6b.done_edge", d_got, W + 1);
        check("t6b.found", 32'(found), 1);
        check("t6b.pos", 32'(match_pos), W - 1);
        repeat (4) @(negedge clk);
        check("t6b.no_extra", hs_count - hs0, 2);

        for (int i = 0; i < 24; i++) begin
            rw = W'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                sp = $urandom_range(0, W - 4);
                rw[W-1-sp -: 4] = 4'b1001;
            end
            rab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W + 2) : 0;
            run_scan($sformatf("rnd%0d", i), rw, rab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
